// File: rtl/bmap_pkg.sv
// Shared constants and index type for the bitmap tag allocator.
package bmap_pkg;
    localparam int unsigned NENT = 96;
    localparam int unsigned IDXW = 7;
    typedef logic [IDXW-1:0] idx_t;
    localparam idx_t IDX_NONE = 7'd127;
endpackage

// File: rtl/bmap_enc.sv
// Free-entry encoders: flz96 returns the lowest free index, ffz96 the highest.
module flz96
    import bmap_pkg::*;
(
    input  logic [NENT-1:0] busy,
    output idx_t            idx
);
    always_comb begin
        idx = IDX_NONE;
        // Scan downward so the lowest free index is the last assignment.
        for (int unsigned i = 0; i < NENT; i++) begin
            if (!busy[NENT-1-i]) idx = idx_t'(NENT - 1 - i);
        end
    end
endmodule

module ffz96
    import bmap_pkg::*;
(
    input  logic [NENT-1:0] busy,
    output idx_t            idx
);
    always_comb begin
        idx = IDX_NONE;
        for (int unsigned i = 0; i < NENT; i++) begin
            if (!busy[i]) idx = idx_t'(i);
        end
    end
endmodule

// File: rtl/bmap_rr_arb.sv
// Round-robin arbiter: first and second requesters at or after the rr pointer.
module bmap_rr_arb #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] rr,
    output logic [NREQ-1:0]         first,
    output logic                    first_vld,
    output logic [NREQ-1:0]         second,
    output logic                    second_vld
);
    always_comb begin
        int unsigned k;
        first      = '0;
        second     = '0;
        first_vld  = 1'b0;
        second_vld = 1'b0;
        for (int unsigned o = 0; o < NREQ; o++) begin
            k = 32'(rr) + o;
            if (k >= NREQ) k = k - NREQ;
            if (req[k]) begin
                if (!first_vld) begin
                    first[k]  = 1'b1;
                    first_vld = 1'b1;
                end else if (!second_vld) begin
                    second[k]  = 1'b1;
                    second_vld = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/bmap_alloc.sv
// 96-entry bitmap allocator with round-robin grant and free port.
// Optional BMAP_DUAL_END_EN adds a second grant from the top of the pool.
module bmap_alloc
    import bmap_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NREQ-1:0]      req_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ*IDXW-1:0] idx_o,
    input  logic                 free_i,
    input  logic [IDXW-1:0]      free_idx_i,
    output logic [NENT-1:0]      busy_o,
    output logic [IDXW-1:0]      count_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 err_o
);
    localparam int unsigned PTRW = $clog2(NREQ);

    logic [PTRW-1:0] rr_q, rr_nxt;
    idx_t            lo_idx, hi_idx;
    logic [NREQ-1:0] first, second, gnt_lo, gnt_hi;
    logic            first_vld, second_vld, lo_grant, dual_grant;
    logic [NENT-1:0] set_vec, clr_vec, fsel;
    logic            free_ok, free_bad;
    logic [1:0]      n_gnt;
    logic [IDXW-1:0] count_nxt;

    flz96 u_flz (.busy(busy_o), .idx(lo_idx));

`ifdef BMAP_DUAL_END_EN
    ffz96 u_ffz (.busy(busy_o), .idx(hi_idx));
`else
    assign hi_idx = IDX_NONE;
`endif

    bmap_rr_arb #(.NREQ(NREQ)) u_arb (
        .req       (req_i),
        .rr        (rr_q),
        .first     (first),
        .first_vld (first_vld),
        .second    (second),
        .second_vld(second_vld)
    );

    assign lo_grant   = first_vld && (lo_idx != IDX_NONE);
    // Equal indices mean a single free entry, which only the winner may take.
    assign dual_grant = lo_grant && second_vld && (hi_idx != IDX_NONE) && (hi_idx != lo_idx);
    assign gnt_lo     = lo_grant ? first : '0;
    assign gnt_hi     = dual_grant ? second : '0;
    assign gnt_o      = gnt_lo | gnt_hi;
    assign n_gnt      = {1'b0, lo_grant} + {1'b0, dual_grant};

    always_comb begin
        idx_o = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (gnt_lo[k])      idx_o[k*IDXW +: IDXW] = lo_idx;
            else if (gnt_hi[k]) idx_o[k*IDXW +: IDXW] = hi_idx;
        end
    end

    always_comb begin
        set_vec = '0;
        fsel    = '0;
        for (int unsigned i = 0; i < NENT; i++) begin
            if (lo_grant && lo_idx == idx_t'(i))   set_vec[i] = 1'b1;
            if (dual_grant && hi_idx == idx_t'(i)) set_vec[i] = 1'b1;
            if (free_idx_i == idx_t'(i))           fsel[i]    = 1'b1;
        end
    end

    assign free_ok   = free_i && |(fsel & busy_o);
    assign free_bad  = free_i && !free_ok;
    assign clr_vec   = free_ok ? fsel : '0;
    assign count_nxt = count_o + IDXW'(n_gnt) - IDXW'(free_ok);

    always_comb begin
        int unsigned last;
        last = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (dual_grant ? second[k] : first[k]) last = k;
        end
        rr_nxt = (last + 1 >= NREQ) ? '0 : PTRW'(last + 1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_o  <= '0;
            count_o <= '0;
            full_o  <= 1'b0;
            empty_o <= 1'b1;
            err_o   <= 1'b0;
            rr_q    <= '0;
        end else begin
            busy_o  <= (busy_o | set_vec) & ~clr_vec;
            count_o <= count_nxt;
            full_o  <= (count_nxt == IDXW'(NENT));
            empty_o <= (count_nxt == '0);
            if (free_bad) err_o <= 1'b1;
            if (lo_grant) rr_q <= rr_nxt;
        end
    end
endmodule

// File: tb/tb_bmap_alloc.sv
// Self-checking bench for bmap_alloc: vector table, corner sequences, random vs model.
module tb_bmap_alloc;
    import bmap_pkg::*;

    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [27:0] idx;
    logic        fr;
    logic [6:0]  fidx;
    logic [95:0] busy;
    logic [6:0]  count;
    logic        full, empty, err;

    always #5 clk = ~clk;

    bmap_alloc #(.NREQ(NREQ)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .idx_o(idx),
        .free_i(fr), .free_idx_i(fidx), .busy_o(busy), .count_o(count),
        .full_o(full), .empty_o(empty), .err_o(err)
    );

    int checks = 0;
    int failures = 0;

    bit mb[96];
    int mcount;
    bit merr;
    int mrr;

    logic [3:0]  s_gnt;
    logic [27:0] s_idx;

    typedef struct {
        bit         rst;
        logic [3:0] req;
        bit         fr;
        logic [6:0] fidx;
        logic [3:0] gnt;
        logic [6:0] idx;
        logic [6:0] cnt;
    } vec_t;
    vec_t tbl[14];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        foreach (mb[i]) mb[i] = 1'b0;
        mcount = 0;
        merr = 1'b0;
        mrr = 0;
    endtask

    // Expected grants: lowest free entry to the first requester in rotating order.
    task automatic model_grant(input logic [3:0] r, output logic [3:0] g,
                               output logic [27:0] ix, output int last);
        int lo = -1;
        int w = -1;
`ifdef BMAP_DUAL_END_EN
        int hi = -1;
        int s = -1;
`endif
        g = '0;
        ix = '0;
        last = -1;
        for (int i = 0; i < 96; i++) begin
            if (!mb[i] && lo < 0) lo = i;
`ifdef BMAP_DUAL_END_EN
            if (!mb[i]) hi = i;
`endif
        end
        for (int o = 0; o < NREQ; o++) begin
            int k = (mrr + o) % NREQ;
            if (r[k] && w < 0) w = k;
`ifdef BMAP_DUAL_END_EN
            else if (r[k] && s < 0) s = k;
`endif
        end
        if (w >= 0 && lo >= 0) begin
            g[w] = 1'b1;
            ix[w*7 +: 7] = 7'(lo);
            last = w;
`ifdef BMAP_DUAL_END_EN
            if (s >= 0 && hi != lo) begin
                g[s] = 1'b1;
                ix[s*7 +: 7] = 7'(hi);
                last = s;
            end
`endif
        end
    endtask

    task automatic step(input logic [3:0] r, input logic f, input logic [6:0] fi);
        logic [3:0]  eg;
        logic [27:0] ei;
        logic [95:0] eb;
        int          last;
        @(negedge clk);
        req = r;
        fr = f;
        fidx = fi;
        #1;
        s_gnt = gnt;
        s_idx = idx;
        model_grant(r, eg, ei, last);
        check("gnt", gnt, eg);
        check("idx", idx, ei);
        if (f) begin
            if (fi < 96 && mb[fi]) begin
                mb[fi] = 1'b0;
                mcount--;
            end else begin
                merr = 1'b1;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (eg[k]) begin
                mb[ei[k*7 +: 7]] = 1'b1;
                mcount++;
            end
        end
        if (last >= 0) mrr = (last + 1) % NREQ;
        @(posedge clk);
        #1;
        for (int i = 0; i < 96; i++) eb[i] = mb[i];
        check("busy", busy, eb);
        check("count", count, mcount);
        check("full", full, mcount == 96);
        check("empty", empty, mcount == 0);
        check("err", err, merr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = '0;
        fr = 1'b0;
        fidx = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_err", err, 0);
        check("rst_gnt", gnt, 0);
        check("rst_idx", idx, 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [95:0] b_snap;
        logic [6:0]  c_snap;
        int          bq[$];
        int          gk;
        rst_n = 1'b1;
        req = '0;
        fr = 1'b0;
        fidx = '0;
        model_clear();
        #2;
        rst_n = 1'b0;
        #10;
        rst_n = 1'b1;

`ifndef BMAP_DUAL_END_EN
        tbl[0]  = '{1'b1, 4'b0001, 1'b0, 7'd0,   4'b0001, 7'd0, 7'd1};
        tbl[1]  = '{1'b0, 4'b1111, 1'b0, 7'd0,   4'b0010, 7'd1, 7'd2};
        tbl[2]  = '{1'b0, 4'b1111, 1'b0, 7'd0,   4'b0100, 7'd2, 7'd3};
        tbl[3]  = '{1'b0, 4'b1111, 1'b0, 7'd0,   4'b1000, 7'd3, 7'd4};
        tbl[4]  = '{1'b0, 4'b1111, 1'b0, 7'd0,   4'b0001, 7'd4, 7'd5};
        tbl[5]  = '{1'b0, 4'b0000, 1'b1, 7'd2,   4'b0000, 7'd0, 7'd4};
        tbl[6]  = '{1'b0, 4'b0100, 1'b0, 7'd0,   4'b0100, 7'd2, 7'd5};
        tbl[7]  = '{1'b1, 4'b1111, 1'b0, 7'd0,   4'b0001, 7'd0, 7'd1};
        tbl[8]  = '{1'b0, 4'b1111, 1'b0, 7'd0,   4'b0010, 7'd1, 7'd2};
        tbl[9]  = '{1'b0, 4'b1111, 1'b0, 7'd0,   4'b0100, 7'd2, 7'd3};
        tbl[10] = '{1'b0, 4'b1111, 1'b0, 7'd0,   4'b1000, 7'd3, 7'd4};
        tbl[11] = '{1'b0, 4'b0000, 1'b1, 7'd100, 4'b0000, 7'd0, 7'd4};
        tbl[12] = '{1'b0, 4'b0010, 1'b1, 7'd1,   4'b0010, 7'd4, 7'd4};
        tbl[13] = '{1'b0, 4'b0010, 1'b0, 7'd0,   4'b0010, 7'd1, 7'd5};
        for (int v = 0; v < 14; v++) begin
            if (tbl[v].rst) do_reset();
            step(tbl[v].req, tbl[v].fr, tbl[v].fidx);
            check($sformatf("tbl%0d_gnt", v), s_gnt, tbl[v].gnt);
            for (int k = 0; k < NREQ; k++) begin
                if (tbl[v].gnt[k]) check($sformatf("tbl%0d_idx", v), s_idx[k*7 +: 7], tbl[v].idx);
            end
            check($sformatf("tbl%0d_count", v), count, tbl[v].cnt);
        end

        // Fill the pool, stall while full, then recycle a freed entry.
        do_reset();
        for (int i = 0; i < 96; i++) step(4'b0001, 1'b0, 7'd0);
        check("full_set", full, 1);
        step(4'b0001, 1'b1, 7'd37);
        check("full_stall_gnt", s_gnt, 4'b0000);
        step(4'b0001, 1'b0, 7'd0);
        check("refill_gnt", s_gnt, 4'b0001);
        check("refill_idx", s_idx[6:0], 7'd37);
        check("refill_full", full, 1);

        // Invalid frees: sticky error, state untouched.
        step(4'b0000, 1'b1, 7'd10);
        b_snap = busy;
        c_snap = count;
        step(4'b0000, 1'b1, 7'd10);
        check("dbl_free_err", err, 1);
        check("dbl_free_busy", busy, b_snap);
        check("dbl_free_count", count, c_snap);
        step(4'b0000, 1'b1, 7'd100);
        check("oor_free_err", err, 1);
        check("oor_free_count", count, c_snap);
        step(4'b0000, 1'b0, 7'd0);
        check("err_sticky", err, 1);
        do_reset();

        // Same-cycle grant and free at count 50.
        for (int i = 0; i < 50; i++) step(4'b0001, 1'b0, 7'd0);
        step(4'b0001, 1'b1, 7'd5);
        check("gf_idx", s_idx[6:0], 7'd50);
        check("gf_count", count, 7'd50);
        step(4'b0001, 1'b0, 7'd0);
        check("gf_next_idx", s_idx[6:0], 7'd5);
`else
        do_reset();
        step(4'b0011, 1'b0, 7'd0);
        check("dual_gnt", s_gnt, 4'b0011);
        check("dual_idx0", s_idx[6:0], 7'd0);
        check("dual_idx1", s_idx[13:7], 7'd95);
        check("dual_count", count, 7'd2);
        for (int i = 0; i < 46; i++) step(4'b0011, 1'b0, 7'd0);
        step(4'b0001, 1'b0, 7'd0);
        check("dual_95", count, 7'd95);
        step(4'b0011, 1'b0, 7'd0);
        check("dual_last_gnt", s_gnt, 4'b0010);
        check("dual_last_count", count, 7'd96);
`endif

        // Random traffic alternating fill-heavy and drain-heavy phases.
        do_reset();
        for (int p = 0; p < 4; p++) begin
            for (int n = 0; n < 150; n++) begin
                logic [3:0] r;
                logic       f;
                logic [6:0] fi;
                r = 4'($urandom_range(0, 15));
                if (p % 2 == 1 && $urandom_range(0, 2) != 0) r = '0;
                f = (p % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                bq.delete();
                for (int i = 0; i < 96; i++) if (mb[i]) bq.push_back(i);
                if (bq.size() > 0 && $urandom_range(0, 9) != 0)
                    fi = 7'(bq[$urandom_range(0, bq.size() - 1)]);
                else
                    fi = 7'($urandom_range(0, 127));
                step(r, f, fi);
            end
        end
        gk = mcount;
        check("rand_count_final", count, gk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
